rr_reg_arbiter: RTL and testbench
=================================

Name: rr_reg_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one DATA_W-bit storage register (bank of d_ff-style flops) among N_REQ requesters.
- Grants exactly one requester at a time, optionally lets it hold ownership for a bounded burst, writes its data into the shared register, and reports the owner.
- Sits between requester blocks and the shared state register in the Basic_sys datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of shared register and each write-data lane
- MAX_HOLD, 4, maximum consecutive write cycles per grant (>=1)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester write request
- lock  input  N_REQ  per-requester "keep grant" hint (valid only with req)
- wdata  input  N_REQ*DATA_W  packed write data, lane i = bits [i*DATA_W +: DATA_W]
- gnt  output  N_REQ  registered one-hot grant, all-zero when idle
- owner  output  $clog2(N_REQ)  index of granted requester, 0 when idle
- q  output  DATA_W  shared register contents
- q_valid  output  1  one-cycle pulse: q updated on the previous edge
- busy  output  1  high while state = OWN

Behaviour:
- Reset (rst=1 at edge): state=IDLE, gnt=0, owner=0, q=0, q_valid=0, busy=0, rr pointer ptr=0, hold_cnt=0. Reset at any point aborts a grant; no write on that edge.
- States: IDLE, OWN.
- Pick function: first requester with req=1 scanning from ptr upward, wrapping at N_REQ-1 -> 0.
- IDLE: if any req at edge -> gnt[pick]=1, owner=pick, hold_cnt=0, state=OWN. No write on that edge. Else stay.
- OWN (granted i): write cycle = gnt[i]&req[i]. On write edge: q<=wdata lane i, q_valid<=1 next cycle, hold_cnt++. Otherwise q_valid<=0.
- Release when at edge: req[i]=0, OR lock[i]=0 (after the write that cycle), OR write with hold_cnt==MAX_HOLD-1.
- On release: ptr<=(i+1) mod N_REQ; re-pick from new ptr over current req excluding nothing (i may win again if sole requester). Any req -> new grant takes effect same edge, no IDLE bubble, hold_cnt=0. None -> IDLE, gnt=0, owner=0.
- Latency: req rising in IDLE at cycle 0 -> gnt at cycle 1 -> first write edge end of cycle 1 -> q and q_valid visible cycle 2.
- Requests not granted are ignored (no write); requesters must hold req until granted.
- Simultaneous requests: strictly round-robin; lowest index at/after ptr wins.
- gnt always one-hot or zero; owner consistent with gnt.
- MAX_HOLD=1: every grant releases after one write.
- Request dropped in same cycle as grant: no write, release at that edge.

Decomposition:
- Package rr_arb_pkg: state typedef (enum logic {IDLE, OWN}), localparam-style helper for index width.
- Sub-module rr_pick: combinational round-robin priority picker (req, ptr -> idx, any); instantiated once.

Test Plan:
- Reset: rst=1 two cycles with req=4'b1111 -> gnt=0, q=0, q_valid=0, owner=0, busy=0.
- Single req: req=4'b0010, lock=0, wdata lane1=8'hA5 at cycle 0 -> gnt=4'b0010 cycle 1, q=8'hA5 and q_valid=1 cycle 2, gnt=4'b0010 again (sole requester re-grant) or 0 if req dropped.
- Contention: req=4'b1111, lock=0, lanes = 8'h10,8'h11,8'h12,8'h13 -> grant order 0,1,2,3,0; q sequence 10,11,12,13,10 one per cycle, no bubbles.
- Hold limit: req=4'b0101, lock=4'b0001, MAX_HOLD=4 -> requester 0 gets 4 consecutive writes, then gnt=4'b0100 next cycle.
- Reset mid-burst: assert rst during requester 2's 2nd write -> q=0, gnt=0, ptr=0; after release with req=4'b0110, requester 1 granted first.
- Drop while granted: requester 3 granted, req[3]=0 same cycle -> no q_valid, gnt moves to next requester or 0.

Source files
------------

// File: rtl/rr_reg_arbiter_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin register arbiter.
package rr_arb_pkg;
    typedef enum logic {IDLE, OWN} state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_reg_arbiter_if.sv
// rr_reg_arbiter_if: requester-side bus of the shared-register arbiter.
interface rr_reg_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [idx_w(N_REQ)-1:0] owner;
    logic [DATA_W-1:0]       q;
    logic                    q_valid;
    logic                    busy;

    modport master (output req, lock, wdata, input gnt, owner, q, q_valid, busy);
    modport slave  (input req, lock, wdata, output gnt, owner, q, q_valid, busy);
endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// rr_pick: first asserted request at or after ptr, wrapping at N-1 -> 0.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [IW-1:0] c;

    assign any_o = |req_i;

    // Scan farthest offset first so the nearest one at/after ptr wins last.
    always_comb begin
        idx_o = '0;
        c     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = IW'((int'(ptr_i) + i) % N);
            if (req_i[c]) idx_o = c;
        end
    end
endmodule

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin owner of a shared DATA_W register with bounded
// lock bursts; a release hands over to the next requester on the same edge.
module rr_reg_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input logic              clk,
    input logic              rst,
    rr_reg_arbiter_if.slave  bus
);
    localparam int IW = idx_w(N_REQ);
    localparam int HW = idx_w(MAX_HOLD);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]      owner_q, owner_d, ptr_q, ptr_d, nxt_ptr, pick_ptr, pick_idx;
    logic [HW-1:0]      hold_q, hold_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic               q_valid_q, q_valid_d, pick_any, wr, rel;

    assign nxt_ptr  = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign wr       = (state_q == OWN) && bus.req[owner_q];
    assign rel      = (state_q == OWN) && (!bus.req[owner_q] || !bus.lock[owner_q] ||
                      (wr && hold_q == HW'(MAX_HOLD - 1)));
    assign pick_ptr = (state_q == OWN) ? nxt_ptr : ptr_q;

    rr_pick #(.N(N_REQ)) u_pick (
        .req_i (bus.req),
        .ptr_i (pick_ptr),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        q_d       = wr ? bus.wdata[owner_q*DATA_W +: DATA_W] : q_q;
        q_valid_d = wr;
        if (wr) hold_d = hold_q + 1'b1;
        if (rel) ptr_d = nxt_ptr;
        if ((state_q == IDLE || rel) && pick_any) begin
            state_d = OWN;
            gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner_d = pick_idx;
            hold_d  = '0;
        end else if (rel) begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = (state_q == OWN);
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: directed vectors with hand-computed expectations.
module tb_rr_reg_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rr_reg_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

    rr_reg_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic obs(input string tag, input int g, input int o, input int qq, input int qv, input int b);
        chk({tag, ".gnt"}, int'(bus.gnt), g);
        chk({tag, ".owner"}, int'(bus.owner), o);
        chk({tag, ".q"}, int'(bus.q), qq);
        chk({tag, ".q_valid"}, int'(bus.q_valid), qv);
        chk({tag, ".busy"}, int'(bus.busy), b);
    endtask

    initial begin
        int exp_g [5] = '{'b0010, 'b0100, 'b1000, 'b0001, 'b0010};
        int exp_q [5] = '{'h10, 'h11, 'h12, 'h13, 'h10};
        bus.req   = 4'b1111;
        bus.lock  = 4'b0000;
        bus.wdata = 32'h0;
        step();
        step();
        obs("reset", 0, 0, 0, 0, 0);

        rst = 1'b0;
        bus.req   = 4'b0010;
        bus.wdata = 32'h0000_A500;
        step();
        obs("single_gnt", 'b0010, 1, 0, 0, 1);
        step();
        obs("single_wr", 'b0010, 1, 'hA5, 1, 1);
        bus.req = 4'b0000;
        step();
        obs("single_drop", 0, 0, 'hA5, 0, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req   = 4'b1111;
        bus.wdata = 32'h1312_1110;
        step();
        obs("cont_gnt", 'b0001, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("cont%0d.q", k), int'(bus.q), exp_q[k]);
            chk($sformatf("cont%0d.q_valid", k), int'(bus.q_valid), 1);
            chk($sformatf("cont%0d.gnt", k), int'(bus.gnt), exp_g[k]);
        end
        bus.req = 4'b0000;
        step();
        obs("cont_idle", 0, 0, 'h10, 0, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req   = 4'b0101;
        bus.lock  = 4'b0001;
        bus.wdata = 32'h0022_0000;
        step();
        obs("hold_gnt", 'b0001, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            bus.wdata[7:0] = 8'(8'h20 + k);
            step();
            chk($sformatf("hold%0d.q", k), int'(bus.q), 'h20 + k);
            chk($sformatf("hold%0d.q_valid", k), int'(bus.q_valid), 1);
            chk($sformatf("hold%0d.gnt", k), int'(bus.gnt), (k < 3) ? 'b0001 : 'b0100);
        end

        bus.lock = 4'b0101;
        step();
        obs("burst_w1", 'b0100, 2, 'h22, 1, 1);
        rst = 1'b1;
        step();
        obs("mid_rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        bus.req   = 4'b0110;
        bus.lock  = 4'b0000;
        bus.wdata = 32'h0032_3100;
        step();
        obs("post_rst", 'b0010, 1, 0, 0, 1);

        bus.req = 4'b1000;
        step();
        obs("to_r3", 'b1000, 3, 0, 0, 1);
        bus.req = 4'b0001;
        step();
        obs("r3_drop", 'b0001, 0, 0, 0, 1);
        bus.req = 4'b0000;
        step();
        obs("final_idle", 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
